// File: rtl/cmplxdiv_pkg.sv
// Shared types for the sequential complex divider.
package cmplxdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cmplxdiv_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first; busy for NW cycles after start.
// No backpressure: the caller holds off start while busy and reads quotient once busy drops.
module cmplxdiv_udiv #(
  parameter int NW = 9,
  parameter int DW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic [NW-1:0] quotient
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  logic [DW-1:0] dsr;
  logic [NW-1:0] shr;
  logic [DW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [DW:0]   sh;
  logic          ge;
  logic [DW-1:0] rem_nx;

  // The partial remainder stays below the divisor, so one extra bit holds the shifted trial value.
  always_comb begin
    sh     = {rem, shr[NW-1]};
    ge     = (sh >= {1'b0, dsr});
    rem_nx = ge ? DW'(sh - {1'b0, dsr}) : sh[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsr      <= '0;
      shr      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      dsr      <= divisor;
      shr      <= dividend;
      rem      <= '0;
      cnt      <= CW'(NW - 1);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      rem      <= rem_nx;
      shr      <= {shr[NW-2:0], 1'b0};
      quotient <= {quotient[NW-2:0], ge};
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cmplxdiv.sv
// Complex divider (product-format dividend / operand-format divisor); fixed 3*DBW+2 cycle latency.
// in_ready only when idle; result held with out_valid until out_ready, no overlap of ops.
module cmplxdiv
  import cmplxdiv_pkg::*;
#(
  parameter int DBW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*DBW-1:0] dvd,
  input  logic [2*DBW-1:0] dvs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*DBW-1:0] quo,
  output logic             ovf,
  output logic             dz
);

  localparam int NW = 3 * DBW;
  localparam int XW = 3 * DBW + 1;
  localparam logic [NW-1:0]  POSLIM = NW'(2 ** (DBW - 1) - 1);
  localparam logic [NW-1:0]  NEGLIM = NW'(2 ** (DBW - 1));
  localparam logic [DBW-1:0] MAXV   = {1'b0, {(DBW - 1){1'b1}}};
  localparam logic [DBW-1:0] MINV   = {1'b1, {(DBW - 1){1'b0}}};

  state_t state, nxt;

  logic [4*DBW-1:0]     dvd_r;
  logic [2*DBW-1:0]     dvs_r;
  logic signed [XW-1:0] dre_x, dim_x, sre_x, sim_x;
  logic signed [XW-1:0] num_re, num_im;
  logic [2*DBW-1:0]     den;
  logic [NW-1:0]        mag_re, mag_im;
  logic [NW-1:0]        q_re, q_im;
  logic                 busy_re, busy_im;
  logic                 neg_re, neg_im, dzero;
  logic                 start, fin;
  logic [DBW:0]         fix_re, fix_im;

  // Returns {clamped, value}: applies the quotient sign to a magnitude and clamps to DBW bits.
  function automatic logic [DBW:0] sat_fix(input logic neg, input logic [NW-1:0] mag);
    logic [DBW-1:0] m;
    m = mag[DBW-1:0];
    if (!neg) sat_fix = (mag > POSLIM) ? {1'b1, MAXV} : {1'b0, m};
    else      sat_fix = (mag > NEGLIM) ? {1'b1, MINV} : {1'b0, {DBW{1'b0}} - m};
  endfunction

  assign dre_x  = XW'($signed(dvd_r[4*DBW-1:2*DBW]));
  assign dim_x  = XW'($signed(dvd_r[2*DBW-1:0]));
  assign sre_x  = XW'($signed(dvs_r[DBW-1:0]));
  assign sim_x  = XW'($signed(dvs_r[2*DBW-1:DBW]));
  assign num_re = dre_x * sre_x + dim_x * sim_x;
  assign num_im = dim_x * sre_x - dre_x * sim_x;
  assign den    = (2 * DBW)'(sre_x * sre_x + sim_x * sim_x);
  assign mag_re = num_re[XW-1] ? NW'(-num_re) : NW'(num_re);
  assign mag_im = num_im[XW-1] ? NW'(-num_im) : NW'(num_im);
  assign start  = (state == LOAD);
  assign fin    = (state == DIV) && !busy_re && !busy_im;
  assign fix_re = sat_fix(neg_re, q_re);
  assign fix_im = sat_fix(neg_im, q_im);

  cmplxdiv_udiv #(.NW(NW), .DW(2 * DBW)) u_div_re (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (mag_re),
    .divisor  (den),
    .busy     (busy_re),
    .quotient (q_re)
  );

  cmplxdiv_udiv #(.NW(NW), .DW(2 * DBW)) u_div_im (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (mag_im),
    .divisor  (den),
    .busy     (busy_im),
    .quotient (q_im)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = LOAD;
      end
      LOAD: nxt = DIV;
      DIV:  if (fin) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r  <= '0;
      dvs_r  <= '0;
      neg_re <= 1'b0;
      neg_im <= 1'b0;
      dzero  <= 1'b0;
      quo    <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        dvd_r <= dvd;
        dvs_r <= dvs;
      end
      if (state == LOAD) begin
        neg_re <= num_re[XW-1];
        neg_im <= num_im[XW-1];
        dzero  <= (den == '0);
      end
      // A zero divisor still runs the full iteration so latency never depends on data.
      if (fin) begin
        if (dzero) begin
          quo <= '0;
          ovf <= 1'b0;
          dz  <= 1'b1;
        end else begin
          quo <= {fix_im[DBW-1:0], fix_re[DBW-1:0]};
          ovf <= fix_re[DBW] | fix_im[DBW];
          dz  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmplxdiv.sv
// Directed bench for cmplxdiv with DBW=3: scoreboard queue of expected results, checked on out_valid.
module tb_cmplxdiv;

  localparam int DBW = 3;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4*DBW-1:0] dvd;
  logic [2*DBW-1:0] dvs;
  logic             out_valid;
  logic             out_ready;
  logic [2*DBW-1:0] quo;
  logic             ovf;
  logic             dz;

  typedef struct packed {
    logic [2*DBW-1:0] quo;
    logic             ovf;
    logic             dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cmplxdiv #(.DBW(DBW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dvd       (dvd),
    .dvs       (dvs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .ovf       (ovf),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input int dre, input int dim, input int sre,
                        input int sim, input int eqre, input int eqim, input logic eovf,
                        input logic edz, input int hold);
    exp_t e;
    exp_t first;
    int   n;
    int   lat;
    e.quo = {DBW'(eqim), DBW'(eqre)};
    e.ovf = eovf;
    e.dz  = edz;
    sb.push_back(e);

    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready_before"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    dvd      = {(2 * DBW)'(dre), (2 * DBW)'(dim)};
    dvs      = {DBW'(sim), DBW'(sre)};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dvd      = ~dvd;
    dvs      = ~dvs;
    chk({name, " in_ready_busy"}, 32'(in_ready), 32'(0));

    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(11));
    first = {quo, ovf, dz};

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, " hold_valid"}, 32'(out_valid), 32'(1));
      chk({name, " hold_in_ready"}, 32'(in_ready), 32'(0));
      chk({name, " hold_stable"}, 32'({quo, ovf, dz}), 32'(first));
    end

    if (sb.size() == 0) begin
      chk({name, " scoreboard_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      chk({name, " quo"}, 32'(quo), 32'(e.quo));
      chk({name, " ovf"}, 32'(ovf), 32'(e.ovf));
      chk({name, " dz"}, 32'(dz), 32'(e.dz));
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " valid_after_hs"}, 32'(out_valid), 32'(0));
    chk({name, " ready_after_hs"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dvd       = '0;
    dvs       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset quo", 32'(quo), 32'(0));
    chk("reset ovf", 32'(ovf), 32'(0));
    chk("reset dz", 32'(dz), 32'(0));
    rst = 1'b0;

    // name, dvd re/im, dvs re/im, expected quo re/im, ovf, dz, backpressure cycles
    run_op("roundtrip",   3, -1,  1, -1,  2,  1, 1'b0, 1'b0, 0);
    run_op("trunc",      -5,  0,  2,  0, -2,  0, 1'b0, 1'b0, 0);
    run_op("sat_pos",    20,  0,  1,  0,  3,  0, 1'b1, 1'b0, 0);
    run_op("sat_neg",   -20,  0,  1,  0, -4,  0, 1'b1, 1'b0, 0);
    run_op("div_zero",    7, -3,  0,  0,  0,  0, 1'b0, 1'b1, 0);
    run_op("backpress",  -4,  7, -2,  1,  3, -2, 1'b0, 1'b0, 5);
    run_op("back2back",   0, -7,  2,  0,  0, -3, 1'b0, 1'b0, 0);
    run_op("neg_limit",  -8,  0,  2,  0, -4,  0, 1'b0, 1'b0, 0);

    // Abort an operation in its 4th DIV cycle.
    @(negedge clk);
    in_valid = 1'b1;
    dvd      = {6'(3), 6'(-1)};
    dvs      = {3'(-1), 3'(1)};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midrst accepted", 32'(in_ready), 32'(0));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'(1));
    chk("midrst out_valid", 32'(out_valid), 32'(0));
    chk("midrst quo", 32'(quo), 32'(0));
    chk("midrst ovf", 32'(ovf), 32'(0));
    chk("midrst dz", 32'(dz), 32'(0));
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst no_stale", 32'(seen), 32'(0));

    run_op("post_reset",  3, -1,  1, -1,  2,  1, 1'b0, 1'b0, 0);

    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
